me_fullsearch_engine: RTL and testbench

- Parametrised full-search block-matching motion estimator. It finds the displacement of a BLK x BLK reference block R inside a search window S with the minimum sum of absolute differences (SAD).
- Next-generation engine behind the testbench start/completed/BestDist/motionX/motionY/AddressR/AddressS handshake. Block size, search range, pixel width and distance width are generalised.
- Adds optional partial-distortion elimination (PDE), which aborts a candidate early once it can no longer win.
- Reads pixels from external synchronous memories with one-cycle read latency.

---
 rtl/me_fullsearch_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_me_fullsearch_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/me_fullsearch_engine.sv
// ---------------------------------------------------------------------------
// me_fullsearch_engine
//
// Full-search block-matching motion estimator. Every candidate displacement
// (cx, cy) of a BLK x BLK reference block inside a SWIN x SWIN search window
// is scored by its sum of absolute differences. The candidate with the
// smallest SAD wins, and ties go to the earlier candidate in raster order.
// With PDE_EN=1, a candidate is abandoned as soon as its partial SAD can no
// longer beat the best so far. The result is identical to the PDE_EN=0 case.
//
// Pixels come from external synchronous memories with a one-cycle read
// latency. R/S carry the data for the addresses driven one cycle earlier.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      launch request (honoured in IDLE or DONE only)
//   R, S       reference / search pixel read data
//   AddressR   reference address, row-major, stride BLK
//   AddressS   search address, row-major, stride SWIN
//   BestDist   minimum SAD, saturated to 2^DIST_W-1
//   motionX    best column offset, 0..2*RANGE-1
//   motionY    best row offset, 0..2*RANGE-1
//   completed  result valid (level, held until next start/reset)
// ---------------------------------------------------------------------------
module me_fullsearch_engine #(
  parameter int PIX_W  = 8,
  parameter int BLK    = 16,
  parameter int RANGE  = 8,
  parameter int DIST_W = 8,
  parameter int PDE_EN = 0,
  localparam int SWIN  = BLK + 2*RANGE - 1,
  localparam int AR_W  = $clog2(BLK*BLK),
  localparam int AS_W  = $clog2(SWIN*SWIN),
  localparam int MV_W  = $clog2(2*RANGE),
  localparam int ACC_W = PIX_W + 2*$clog2(BLK)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  R,
  input  logic [PIX_W-1:0]  S,
  output logic [AR_W-1:0]   AddressR,
  output logic [AS_W-1:0]   AddressS,
  output logic [DIST_W-1:0] BestDist,
  output logic [MV_W-1:0]   motionX,
  output logic [MV_W-1:0]   motionY,
  output logic              completed
);

  localparam int LB = $clog2(BLK);
  localparam int XW = (ACC_W > DIST_W) ? ACC_W : DIST_W;
  localparam logic [LB-1:0]   PIX_MAX = LB'(BLK - 1);
  localparam logic [MV_W-1:0] MV_MAX  = MV_W'(2*RANGE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    logic signed [PIX_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    abs_diff = (d < 0) ? PIX_W'(-d) : PIX_W'(d);
  endfunction

  function automatic logic [DIST_W-1:0] sat_dist(input logic [ACC_W-1:0] v);
    logic [XW-1:0] vx;
    logic [XW-1:0] mx;
    vx = XW'(v);
    mx = XW'({DIST_W{1'b1}});
    sat_dist = (vx > mx) ? {DIST_W{1'b1}} : DIST_W'(vx);
  endfunction

  state_t            state;

  logic [LB-1:0]     px_p0, py_p0, npx, npy;
  logic [MV_W-1:0]   cx_p0, cy_p0, ncx, ncy;
  logic              vld_p0;

  logic              vld_p1, first_p1, last_p1;
  logic [MV_W-1:0]   cx_p1, cy_p1;

  logic [ACC_W-1:0]  acc_p2, best_p2;
  logic [MV_W-1:0]   bcx_p2, bcy_p2;
  logic              best_vld;

  logic [PIX_W-1:0]  absd_p1;
  logic [ACC_W-1:0]  sum_p1, best_nxt;
  logic [MV_W-1:0]   bcx_nxt, bcy_nxt;
  logic              best_vld_nxt, better, abort;
  logic              pix_first, pix_last, cand_last, wrap_cand, scan_end;
  logic              launch, advance;
  logic [AR_W-1:0]   ar_nxt;
  logic [AS_W-1:0]   as_nxt;

  // ---- stage p1 -> p2: accumulate |R-S|, compare at candidate end ----
  always_comb begin
    absd_p1      = abs_diff(R, S);
    sum_p1       = first_p1 ? ACC_W'(absd_p1) : acc_p2 + ACC_W'(absd_p1);
    better       = vld_p1 && last_p1 && (!best_vld || (sum_p1 < best_p2));
    // On the last pixel a losing candidate is simply not taken, so the
    // early abort only needs to cover the pixels before it.
    abort        = (PDE_EN != 0) && vld_p1 && !last_p1 && best_vld &&
                   (sum_p1 >= best_p2);
    best_nxt     = better ? sum_p1 : best_p2;
    bcx_nxt      = better ? cx_p1  : bcx_p2;
    bcy_nxt      = better ? cy_p1  : bcy_p2;
    best_vld_nxt = best_vld || better;
  end

  // ---- stage p0: address generation ----
  // An abort always refers to the candidate currently held in p0: the
  // in-flight read is never the last pixel of the aborting candidate's
  // predecessor, because aborts are suppressed on last pixels.
  always_comb begin
    pix_first = (px_p0 == '0) && (py_p0 == '0);
    pix_last  = (px_p0 == PIX_MAX) && (py_p0 == PIX_MAX);
    cand_last = (cx_p0 == MV_MAX) && (cy_p0 == MV_MAX);
    wrap_cand = pix_last || abort;
    scan_end  = wrap_cand && cand_last;
    launch    = ((state == IDLE) || (state == DONE)) && start;
    advance   = (state == RUN) && !scan_end;

    npx = px_p0 + LB'(1);
    npy = py_p0;
    ncx = cx_p0;
    ncy = cy_p0;
    if (wrap_cand) begin
      npx = '0;
      npy = '0;
      if (cx_p0 == MV_MAX) begin
        ncx = '0;
        ncy = cy_p0 + MV_W'(1);
      end else begin
        ncx = cx_p0 + MV_W'(1);
      end
    end else if (px_p0 == PIX_MAX) begin
      npx = '0;
      npy = py_p0 + LB'(1);
    end

    ar_nxt = AR_W'({npy, npx});
    as_nxt = (AS_W'(ncy) + AS_W'(npy)) * AS_W'(SWIN) + AS_W'(ncx) + AS_W'(npx);
  end

  // Control path: FSM, valids, best validity and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      AddressR  <= '0;
      AddressS  <= '0;
      BestDist  <= '0;
      motionX   <= '0;
      motionY   <= '0;
      completed <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      best_vld  <= 1'b0;
    end else begin
      vld_p1   <= vld_p0 && !abort;
      best_vld <= best_vld_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            completed <= 1'b0;
            AddressR  <= '0;
            AddressS  <= '0;
            vld_p0    <= 1'b1;
            best_vld  <= 1'b0;
          end
        end
        RUN: begin
          if (scan_end) begin
            state  <= DRAIN;
            vld_p0 <= 1'b0;
          end else begin
            AddressR <= ar_nxt;
            AddressS <= as_nxt;
            vld_p0   <= 1'b1;
          end
        end
        DRAIN: begin
          // The final pixel is compared in this cycle, so publish the
          // post-compare best directly.
          state     <= DONE;
          completed <= 1'b1;
          BestDist  <= sat_dist(best_nxt);
          motionX   <= bcx_nxt;
          motionY   <= bcy_nxt;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers: counters, pipeline metadata, accumulator, best.
  always_ff @(posedge clk) begin
    if (launch) begin
      px_p0 <= '0;
      py_p0 <= '0;
      cx_p0 <= '0;
      cy_p0 <= '0;
    end else if (advance) begin
      px_p0 <= npx;
      py_p0 <= npy;
      cx_p0 <= ncx;
      cy_p0 <= ncy;
    end
    // ---- p0 -> p1 ----
    first_p1 <= pix_first;
    last_p1  <= pix_last;
    cx_p1    <= cx_p0;
    cy_p1    <= cy_p0;
    // ---- p1 -> p2 ----
    if (vld_p1) acc_p2 <= sum_p1;
    best_p2 <= best_nxt;
    bcx_p2  <= bcx_nxt;
    bcy_p2  <= bcy_nxt;
  end

endmodule

// File: tb/tb_me_fullsearch_engine.sv
// ---------------------------------------------------------------------------
// tb_me_fullsearch_engine
//
// Bench for me_fullsearch_engine with a small geometry (BLK=4, RANGE=2) so
// one search takes 258 cycles. Two instances, one without and one with
// partial-distortion elimination, share clock, reset, start and memory
// contents, but each has its own pair of synchronous read ports.
// ---------------------------------------------------------------------------
module tb_me_fullsearch_engine;

  localparam int BLK  = 4;
  localparam int RNG  = 2;
  localparam int NC   = 2*RNG;
  localparam int SWIN = BLK + 2*RNG - 1;
  localparam int LAT  = NC*NC*BLK*BLK + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] r0, s0, r1, s1;
  logic [3:0] ar0, ar1;
  logic [5:0] as0, as1;
  logic [7:0] bd0, bd1;
  logic [1:0] mx0, my0, mx1, my1;
  logic       cmp0, cmp1;

  logic [7:0] mem_r [16];
  logic [7:0] mem_s [64];

  int n_tests = 0;
  int n_fail  = 0;
  int lat0, lat1;
  int any_faster = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    r0 <= mem_r[ar0];
    s0 <= mem_s[as0];
    r1 <= mem_r[ar1];
    s1 <= mem_s[as1];
  end

  me_fullsearch_engine #(.PIX_W(8), .BLK(BLK), .RANGE(RNG), .DIST_W(8), .PDE_EN(0)) dut (
    .clk(clk), .reset(reset), .start(start), .R(r0), .S(s0),
    .AddressR(ar0), .AddressS(as0), .BestDist(bd0),
    .motionX(mx0), .motionY(my0), .completed(cmp0));

  me_fullsearch_engine #(.PIX_W(8), .BLK(BLK), .RANGE(RNG), .DIST_W(8), .PDE_EN(1)) dut_pde (
    .clk(clk), .reset(reset), .start(start), .R(r1), .S(s1),
    .AddressR(ar1), .AddressS(as1), .BestDist(bd1),
    .motionX(mx1), .motionY(my1), .completed(cmp1));

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference full search over the memory images.
  function automatic void model(output int sad, output int mx, output int my);
    int best;
    best = -1;
    mx = 0;
    my = 0;
    for (int cy = 0; cy < NC; cy++)
      for (int cx = 0; cx < NC; cx++) begin
        int s;
        s = 0;
        for (int py = 0; py < BLK; py++)
          for (int px = 0; px < BLK; px++) begin
            int a, b;
            a = int'(mem_r[py*BLK+px]);
            b = int'(mem_s[(cy+py)*SWIN+cx+px]);
            s += (a > b) ? a - b : b - a;
          end
        if (best < 0 || s < best) begin
          best = s;
          mx = cx;
          my = cy;
        end
      end
    sad = best;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem_r[i] = 8'h00;
    for (int i = 0; i < 64; i++) mem_s[i] = 8'h00;
  endtask

  // S random and nonzero, R copied from S at displacement (cx, cy).
  task automatic fill_copy(input int cx, input int cy);
    clear_mem();
    for (int i = 0; i < SWIN*SWIN; i++) mem_s[i] = 8'($urandom_range(1, 255));
    for (int py = 0; py < BLK; py++)
      for (int px = 0; px < BLK; px++)
        mem_r[py*BLK+px] = mem_s[(cy+py)*SWIN+cx+px];
  endtask

  task automatic fill_const(input logic [7:0] rv, input logic [7:0] sv);
    clear_mem();
    for (int i = 0; i < 16; i++) mem_r[i] = rv;
    for (int i = 0; i < SWIN*SWIN; i++) mem_s[i] = sv;
  endtask

  // Called right after a negedge. Optionally pulses start again mid-run.
  task automatic run_search(input int mid_start_at);
    lat0 = -1;
    lat1 = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cmpl_clear_dut", cmp0, 0);
    check("cmpl_clear_pde", cmp1, 0);
    for (int n = 1; n <= 2000; n++) begin
      start = (n == mid_start_at);
      if (lat0 < 0 && cmp0) lat0 = n;
      if (lat1 < 0 && cmp1) lat1 = n;
      if (lat0 >= 0 && lat1 >= 0) break;
      @(negedge clk);
    end
    start = 1'b0;
    check("run_finished", int'(lat0 >= 0 && lat1 >= 0), 1);
    if (lat1 >= 0 && lat1 < LAT) any_faster = 1;
  endtask

  task automatic check_result(input string tag, input int sad, input int mx, input int my);
    int sat;
    sat = (sad > 255) ? 255 : sad;
    check({tag, "_bestdist"},     bd0, sat);
    check({tag, "_motionx"},      mx0, mx);
    check({tag, "_motiony"},      my0, my);
    check({tag, "_pde_bestdist"}, bd1, sat);
    check({tag, "_pde_motionx"},  mx1, mx);
    check({tag, "_pde_motiony"},  my1, my);
    check({tag, "_latency"},      lat0, LAT);
    check({tag, "_pde_lat_le"},   int'(lat1 >= 0 && lat1 <= LAT), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_completed"}, cmp0, 0);
    check({tag, "_bestdist"},  bd0, 0);
    check({tag, "_motionx"},   mx0, 0);
    check({tag, "_motiony"},   my0, 0);
    check({tag, "_addr_r"},    ar0, 0);
    check({tag, "_addr_s"},    as0, 0);
    check({tag, "_pde_completed"}, cmp1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish within budget");
    $fatal(1);
  end

  initial begin
    int esad, emx, emy;
    reset = 1'b1;
    start = 1'b1;          // reset must win over a simultaneous start
    clear_mem();
    repeat (3) @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check_zero("reset");
    repeat (2) @(negedge clk);

    // Exact copy at (3,1): SAD 0 there, nonzero elsewhere.
    fill_copy(3, 1);
    run_search(0);
    check_result("copy31", 0, 3, 1);

    // Flat images: all SADs zero, the first candidate wins. Also a start
    // pulse in the middle of the run that must be ignored, and a start in
    // DONE that must clear completed.
    fill_const(8'h20, 8'h20);
    @(negedge clk);
    run_search(50);
    check_result("flat", 0, 0, 0);

    // Maximum difference: 16*255 = 4080, BestDist saturates to 255.
    fill_const(8'hFF, 8'h00);
    run_search(0);
    check_result("sat", 4080, 0, 0);

    // Reset in the middle of a run discards everything.
    fill_copy(2, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("midreset");
    repeat (3) @(negedge clk);
    check("midreset_idle_addr", ar0, 0);
    check("midreset_idle_cmpl", cmp0, 0);
    run_search(0);
    check_result("after_reset", 0, 2, 3);

    // Randomised images against the reference model, both instances.
    for (int seed = 0; seed < 20; seed++) begin
      clear_mem();
      if (seed % 2 == 0) begin
        int cx, cy;
        cx = $urandom_range(0, NC-1);
        cy = $urandom_range(0, NC-1);
        for (int i = 0; i < SWIN*SWIN; i++) mem_s[i] = 8'($urandom_range(0, 200));
        for (int py = 0; py < BLK; py++)
          for (int px = 0; px < BLK; px++)
            mem_r[py*BLK+px] = mem_s[(cy+py)*SWIN+cx+px] + 8'($urandom_range(0, 3));
      end else begin
        for (int i = 0; i < SWIN*SWIN; i++) mem_s[i] = 8'($urandom_range(0, 15));
        for (int i = 0; i < 16; i++) mem_r[i] = 8'($urandom_range(0, 15));
      end
      model(esad, emx, emy);
      run_search(0);
      check_result($sformatf("rand%0d", seed), esad, emx, emy);
    end
    check("pde_some_run_faster", any_faster, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
